motor_pwm_ramp: RTL and testbench
=================================

# motor_pwm_ramp

Multi-channel H-bridge motor driver: per channel a direction pair and a PWM enable, driven from a shared PWM counter. Each channel soft-ramps its duty toward a commanded target and performs safe direction reversals (ramp to zero, dead time, switch, ramp up). It sits between the control logic, which issues valid/ready commands, and the H-bridge pins.

## Interface
- CHANNELS, 2, number of motor channels (1..8)
- DUTY_W, 8, duty/counter width; PWM period = 2^DUTY_W ticks
- PRESCALE, 4, clk cycles per PWM tick (>=1)
- RAMP_STEP, 4, duty change per PWM period while ramping (>=1)
- DEAD_PERIODS, 2, full PWM periods of dead time on reversal (>=1)

- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- cmd_valid  in  1  command strobe
- cmd_ready  out  1  command accept
- cmd_ch  in  3  target channel
- cmd_en  in  1  1 = run, 0 = stop
- cmd_dir  in  1  1 = forward, 0 = reverse
- cmd_duty  in  DUTY_W  target duty
- IN  out  2*CHANNELS  bridge inputs; channel c on IN[2c+1:2c]
- EN  out  CHANNELS  PWM enable per channel
- busy  out  CHANNELS  channel ramping or in reversal

## Operation
- Reset (rst_n=0 at a clk edge): IN=0, EN=0, busy=0, cmd_ready=0, PWM counter=0, prescaler=0, every channel STOP, cur_duty=0, cur_dir=1, targets 0/dir 1/en 0.
- cmd_ready=1 in every cycle after reset is released. A command is accepted when cmd_valid&&cmd_ready; it writes tgt_en/tgt_dir/tgt_duty of cmd_ch. cmd_ch>=CHANNELS: accepted, ignored.
- Shared counter cnt (DUTY_W bits) increments on each tick and wraps; wrap = tick && cnt==all-ones.
- IN encoding per channel: forward 2'b10, reverse 2'b01, coast 2'b00.
- EN[c] = (state RUN or RAMP_DOWN) && cnt < cur_duty. cur_duty=0 gives constant 0; max duty gives (2^DUTY_W-1)/2^DUTY_W.
- States per channel:
  - STOP: IN=00, cur_duty=0. tgt_en=1 -> cur_dir<=tgt_dir, RUN.
  - RUN: IN by cur_dir. On each wrap cur_duty moves toward tgt_duty by RAMP_STEP, saturating exactly at target (no overshoot, no wrap-around). tgt_en=0 or tgt_dir!=cur_dir -> RAMP_DOWN (direct to DEAD/STOP if cur_duty already 0).
  - RAMP_DOWN: IN by cur_dir; on each wrap cur_duty steps toward 0 (saturating). At cur_duty=0: tgt_en=0 -> STOP; tgt_dir!=cur_dir -> DEAD; otherwise (command reverted) -> RUN.
  - DEAD: IN=00, EN=0; counts DEAD_PERIODS wraps, then cur_dir<=tgt_dir and RUN if tgt_en else STOP.
- Commands landing in RAMP_DOWN/DEAD only update targets; they are evaluated at the exit conditions above.
- busy[c] = state in {RAMP_DOWN, DEAD} or (RUN and cur_duty!=tgt_duty).
- Channels are fully independent apart from the shared counter.

## Timing
- Accepted command visible in targets next cycle; state transitions from targets occur the cycle after that.
- Duty steps occur only on wrap cycles; one step per PWM period (PRESCALE*2^DUTY_W clk).
- IN, EN, busy are registered: EN reflects cnt/cur_duty of the previous cycle.
- DEAD lasts exactly DEAD_PERIODS wraps, counted from the first wrap after entry.
- Reset asserted mid-ramp or mid-DEAD: all outputs 0 on the next edge, no ramp-down.
- Command and wrap in the same cycle: the step uses the old target; the new target applies from the next wrap.

## Configuration
- MOTOR_BRAKE_EN defined: in DEAD, IN=2'b11 (active brake), EN=1 constant; in STOP, IN=00, EN=0.
- Undefined: DEAD drives IN=00, EN=0 (coast), as in Operation.

## Test plan
(DUTY_W=4, PRESCALE=1, RAMP_STEP=4, DEAD_PERIODS=2, CHANNELS=2)
- Reset: rst_n=0 for 3 cycles -> IN=0, EN=0, busy=0, cmd_ready=0; cmd_ready=1 first cycle after release.
- Ch0 cmd en=1 dir=1 duty=10 -> IN[1:0]=10; cur_duty 4, 8, 10 on successive wraps; EN[0] high 10 of 16 clk per period after settling; busy[0] drops at 10.
- Ch0 at 10 forward, cmd dir=0 duty=8 -> duty 6, 2, 0 over 3 wraps, IN=00 for 2 periods, then IN=01, duty 4, 8.
- Reversal then revert: cmd dir=0, then dir=1 during RAMP_DOWN -> reaches 0, returns to RUN forward, no DEAD.
- cmd_ch=5 duty=15 -> accepted, no output change on any channel; reset mid-DEAD -> all outputs 0 next cycle.
- With MOTOR_BRAKE_EN: reversal -> IN[1:0]=11, EN[0]=1 for 32 clk between ramps.

Source files
------------

// File: rtl/motor_pwm_ramp.sv
// -----------------------------------------------------------------------------
// motor_pwm_ramp
//
// Multi-channel H-bridge motor driver. A shared prescaled PWM counter drives
// every channel. Each channel soft-ramps its duty toward a commanded target
// and performs safe direction reversals: ramp to zero, dead time, switch
// direction, ramp back up.
//
// Optional feature macro: MOTOR_BRAKE_EN
//   defined   : dead time actively brakes (IN pair = 2'b11, EN = 1)
//   undefined : dead time coasts (IN pair = 2'b00, EN = 0)
//
// Ports (top):
//   clk        system clock
//   rst_n      synchronous reset, active-low
//   cmd_valid  command strobe
//   cmd_ready  command accept (1 in every cycle after reset is released)
//   cmd_ch     target channel; values >= CHANNELS are accepted and dropped
//   cmd_en     1 = run, 0 = stop
//   cmd_dir    1 = forward, 0 = reverse
//   cmd_duty   target duty
//   IN         bridge inputs, channel c on IN[2c+1:2c] (fwd 10, rev 01)
//   EN         PWM enable per channel
//   busy       channel ramping or in a reversal
// -----------------------------------------------------------------------------

// Per-channel ramp / reversal controller.
//   clk, rst_n  clock and synchronous active-low reset
//   wrap        shared PWM counter wraps this cycle (duty steps happen here)
//   cnt         shared PWM counter value
//   wr          write this channel's targets (wr_en / wr_dir / wr_duty)
//   bridge      registered IN pair for this channel
//   en          registered PWM enable
//   busy        registered busy flag
module motor_pwm_ramp_ch #(
   parameter int DUTY_W       = 8,
   parameter int RAMP_STEP    = 4,
   parameter int DEAD_PERIODS = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wrap,
   input  logic [DUTY_W-1:0] cnt,
   input  logic              wr,
   input  logic              wr_en,
   input  logic              wr_dir,
   input  logic [DUTY_W-1:0] wr_duty,
   output logic [1:0]        bridge,
   output logic              en,
   output logic              busy
);

   localparam int DCW = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
   localparam logic [DCW-1:0] DEAD_LAST = DCW'(DEAD_PERIODS - 1);

   typedef enum logic [1:0] {
      ST_STOP      = 2'd0,
      ST_RUN       = 2'd1,
      ST_RAMP_DOWN = 2'd2,
      ST_DEAD      = 2'd3
   } state_t;

   state_t            state;
   logic [DUTY_W-1:0] cur_duty;
   logic              cur_dir;
   logic              tgt_en;
   logic              tgt_dir;
   logic [DUTY_W-1:0] tgt_duty;
   logic [DCW-1:0]    dead_cnt;

   // Target asks the motor to stop or turn around: ramp toward zero first.
   logic leave;
   assign leave = !tgt_en || (tgt_dir != cur_dir);

   // Move cur toward tgt by at most RAMP_STEP, landing exactly on tgt.
   // Done in 32-bit so large RAMP_STEP values can never wrap the duty.
   function automatic logic [DUTY_W-1:0] step_to(input logic [DUTY_W-1:0] cur,
                                                 input logic [DUTY_W-1:0] tgt);
      int unsigned c;
      int unsigned t;
      c = 32'(cur);
      t = 32'(tgt);
      if (c < t)
         return ((t - c) <= RAMP_STEP) ? tgt : DUTY_W'(c + RAMP_STEP);
      else if (c > t)
         return ((c - t) <= RAMP_STEP) ? tgt : DUTY_W'(c - RAMP_STEP);
      return cur;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_STOP;
         cur_duty <= '0;
         cur_dir  <= 1'b1;
         tgt_en   <= 1'b0;
         tgt_dir  <= 1'b1;
         tgt_duty <= '0;
         dead_cnt <= '0;
         bridge   <= 2'b00;
         en       <= 1'b0;
         busy     <= 1'b0;
      end else begin
         // Targets: the state logic below still sees the old values this
         // cycle, so a command colliding with a wrap steps on the old target.
         if (wr) begin
            tgt_en   <= wr_en;
            tgt_dir  <= wr_dir;
            tgt_duty <= wr_duty;
         end

         // Registered outputs, derived from this cycle's state / cnt / duty.
         case (state)
            ST_RUN, ST_RAMP_DOWN: begin
               bridge <= cur_dir ? 2'b10 : 2'b01;
               en     <= (cnt < cur_duty);
            end
            ST_DEAD: begin
`ifdef MOTOR_BRAKE_EN
               bridge <= 2'b11;
               en     <= 1'b1;
`else
               bridge <= 2'b00;
               en     <= 1'b0;
`endif
            end
            default: begin
               bridge <= 2'b00;
               en     <= 1'b0;
            end
         endcase
         busy <= (state == ST_RAMP_DOWN) || (state == ST_DEAD) ||
                 ((state == ST_RUN) && (cur_duty != tgt_duty));

         case (state)
            ST_STOP: begin
               cur_duty <= '0;
               if (tgt_en) begin
                  cur_dir <= tgt_dir;
                  state   <= ST_RUN;
               end
            end

            ST_RUN: begin
               if (leave) begin
                  if (cur_duty == '0) begin
                     // Nothing to ramp down: go straight to the exit.
                     if (!tgt_en) begin
                        state <= ST_STOP;
                     end else begin
                        state    <= ST_DEAD;
                        dead_cnt <= '0;
                     end
                  end else begin
                     state <= ST_RAMP_DOWN;
                     if (wrap)
                        cur_duty <= step_to(cur_duty, '0);
                  end
               end else if (wrap) begin
                  cur_duty <= step_to(cur_duty, tgt_duty);
               end
            end

            ST_RAMP_DOWN: begin
               // Targets are only re-evaluated once the duty reaches zero.
               if (cur_duty == '0) begin
                  if (!tgt_en) begin
                     state <= ST_STOP;
                  end else if (tgt_dir != cur_dir) begin
                     state    <= ST_DEAD;
                     dead_cnt <= '0;
                  end else begin
                     state <= ST_RUN;
                  end
               end else if (wrap) begin
                  cur_duty <= step_to(cur_duty, '0);
               end
            end

            default: begin // ST_DEAD
               // Counts wraps seen while already in DEAD; the entry wrap
               // (if any) does not count.
               if (wrap) begin
                  if (dead_cnt == DEAD_LAST) begin
                     cur_dir <= tgt_dir;
                     state   <= tgt_en ? ST_RUN : ST_STOP;
                  end else begin
                     dead_cnt <= dead_cnt + 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule

module motor_pwm_ramp #(
   parameter int CHANNELS     = 2,
   parameter int DUTY_W       = 8,
   parameter int PRESCALE     = 4,
   parameter int RAMP_STEP    = 4,
   parameter int DEAD_PERIODS = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [2:0]            cmd_ch,
   input  logic                  cmd_en,
   input  logic                  cmd_dir,
   input  logic [DUTY_W-1:0]     cmd_duty,
   output logic [2*CHANNELS-1:0] IN,
   output logic [CHANNELS-1:0]   EN,
   output logic [CHANNELS-1:0]   busy
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0]     presc;
   logic [DUTY_W-1:0] cnt;
   logic              tick;
   logic              wrap;
   logic              accept;

   assign tick   = (presc == PRE_LAST);
   assign wrap   = tick && (cnt == '1);
   assign accept = cmd_valid && cmd_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc     <= '0;
         cnt       <= '0;
         cmd_ready <= 1'b0;
      end else begin
         cmd_ready <= 1'b1;
         presc     <= tick ? '0 : presc + 1'b1;
         if (tick)
            cnt <= cnt + 1'b1;
      end
   end

   logic [CHANNELS-1:0][1:0] bridge;
   assign IN = bridge;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      motor_pwm_ramp_ch #(
         .DUTY_W       (DUTY_W),
         .RAMP_STEP    (RAMP_STEP),
         .DEAD_PERIODS (DEAD_PERIODS)
      ) u_ch (
         .clk     (clk),
         .rst_n   (rst_n),
         .wrap    (wrap),
         .cnt     (cnt),
         .wr      (accept && (cmd_ch == 3'(c))),
         .wr_en   (cmd_en),
         .wr_dir  (cmd_dir),
         .wr_duty (cmd_duty),
         .bridge  (bridge[c]),
         .en      (EN[c]),
         .busy    (busy[c])
      );
   end

endmodule

// File: tb/tb_motor_pwm_ramp.sv
// Bench for motor_pwm_ramp: directed steps from the test plan followed by
// randomized commands/resets, checked every cycle against a behavioural model.
module tb_motor_pwm_ramp;

   localparam int CH = 2, W = 4, PRE = 1, STEP = 4, DP = 2;
   localparam int MAXV = (1 << W) - 1;
`ifdef MOTOR_BRAKE_EN
   localparam bit BRAKE = 1'b1;
`else
   localparam bit BRAKE = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [2:0]    cmd_ch = '0;
   logic          cmd_en = 1'b0;
   logic          cmd_dir = 1'b1;
   logic [W-1:0]  cmd_duty = '0;
   logic [2*CH-1:0] IN;
   logic [CH-1:0] EN;
   logic [CH-1:0] busy;

   always #5 clk = ~clk;

   motor_pwm_ramp #(.CHANNELS(CH), .DUTY_W(W), .PRESCALE(PRE),
                    .RAMP_STEP(STEP), .DEAD_PERIODS(DP)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_ch(cmd_ch), .cmd_en(cmd_en), .cmd_dir(cmd_dir), .cmd_duty(cmd_duty),
      .IN(IN), .EN(EN), .busy(busy));

   int checks = 0;
   int failures = 0;

   // ---------------- behavioural model ----------------
   typedef enum int {M_STOP, M_RUN, M_DOWN, M_DEAD} phase_t;
   phase_t ph[CH];
   int duty[CH], dirv[CH], te[CH], td[CH], tduty[CH], dk[CH];
   int m_cnt, m_pre, m_rdy;
   logic [2*CH-1:0] x_in;
   logic [CH-1:0]   x_en, x_busy;

   function automatic int approach(input int c, input int t);
      if (c < t) return (c + STEP > t) ? t : c + STEP;
      return (c - STEP < t) ? t : c - STEP;
   endfunction

   // Advance the model across one rising edge using the inputs now applied.
   task automatic model_edge();
      int tick, wrp, off, nd;
      if (!rst_n) begin
         m_cnt = 0; m_pre = 0; m_rdy = 0;
         x_in = '0; x_en = '0; x_busy = '0;
         for (int c = 0; c < CH; c++) begin
            ph[c] = M_STOP; duty[c] = 0; dirv[c] = 1;
            te[c] = 0; td[c] = 1; tduty[c] = 0; dk[c] = 0;
         end
         return;
      end
      tick = (m_pre == PRE - 1);
      wrp  = tick && (m_cnt == MAXV);
      for (int c = 0; c < CH; c++) begin
         if (ph[c] == M_RUN || ph[c] == M_DOWN) begin
            x_in[2*c +: 2] = (dirv[c] != 0) ? 2'b10 : 2'b01;
            x_en[c] = (m_cnt < duty[c]);
         end else if (ph[c] == M_DEAD && BRAKE) begin
            x_in[2*c +: 2] = 2'b11;
            x_en[c] = 1'b1;
         end else begin
            x_in[2*c +: 2] = 2'b00;
            x_en[c] = 1'b0;
         end
         x_busy[c] = (ph[c] == M_DOWN) || (ph[c] == M_DEAD) ||
                     (ph[c] == M_RUN && duty[c] != tduty[c]);
         off = (te[c] == 0) || (td[c] != dirv[c]);
         case (ph[c])
            M_STOP: if (te[c] != 0) begin dirv[c] = td[c]; ph[c] = M_RUN; end
            M_RUN: begin
               nd = wrp ? approach(duty[c], off ? 0 : tduty[c]) : duty[c];
               if (off) begin
                  if (duty[c] != 0) ph[c] = M_DOWN;
                  else if (te[c] != 0) begin ph[c] = M_DEAD; dk[c] = 0; end
                  else ph[c] = M_STOP;
               end
               duty[c] = nd;
            end
            M_DOWN: begin
               if (duty[c] == 0) begin
                  if (te[c] == 0) ph[c] = M_STOP;
                  else if (td[c] != dirv[c]) begin ph[c] = M_DEAD; dk[c] = 0; end
                  else ph[c] = M_RUN;
               end else if (wrp) duty[c] = approach(duty[c], 0);
            end
            default: if (wrp) begin
               dk[c]++;
               if (dk[c] == DP) begin
                  dirv[c] = td[c];
                  ph[c] = (te[c] != 0) ? M_RUN : M_STOP;
               end
            end
         endcase
      end
      if (cmd_valid && m_rdy != 0 && int'(cmd_ch) < CH) begin
         te[cmd_ch] = int'(cmd_en); td[cmd_ch] = int'(cmd_dir);
         tduty[cmd_ch] = int'(cmd_duty);
      end
      if (tick != 0) m_cnt = (m_cnt + 1) & MAXV;
      m_pre = (tick != 0) ? 0 : m_pre + 1;
      m_rdy = 1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: model steps with the edge, outputs compared 1 time unit later.
   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      chk("cmd_ready", 32'(cmd_ready), 32'(m_rdy));
      chk("IN", 32'(IN), 32'(x_in));
      chk("EN", 32'(EN), 32'(x_en));
      chk("busy", 32'(busy), 32'(x_busy));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic send(input int ch, input bit e, input bit d, input int du);
      cmd_valid = 1'b1; cmd_ch = 3'(ch); cmd_en = e; cmd_dir = d; cmd_duty = W'(du);
      cyc();
      cmd_valid = 1'b0;
   endtask

   initial begin
      int hi;
      bit seen;
      // Reset held for 3 cycles.
      rst_n = 1'b0;
      run(3);
      chk("rst_IN", 32'(IN), 32'h0);
      chk("rst_EN", 32'(EN), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_ready", 32'(cmd_ready), 32'h0);
      rst_n = 1'b1;
      cyc();
      chk("ready_after_release", 32'(cmd_ready), 32'h1);

      // Ch0 forward, duty 10: ramps 4, 8, 10.
      send(0, 1'b1, 1'b1, 10);
      run(80);
      hi = 0;
      for (int i = 0; i < 16; i++) begin cyc(); hi += int'(EN[0]); end
      chk("en0_high_per_period", 32'(hi), 32'd10);
      chk("fwd_IN0", 32'(IN[1:0]), 32'h2);
      chk("busy0_settled", 32'(busy[0]), 32'h0);

      // Reverse to duty 8: down 6,2,0, dead, then reverse up 4, 8.
      send(0, 1'b1, 1'b0, 8);
      seen = 1'b0;
      for (int i = 0; i < 150; i++) begin
         cyc();
         if (IN[1:0] == 2'b00 || IN[1:0] == 2'b11) seen = 1'b1;
      end
      chk("dead_seen", 32'(seen), 32'h1);
      chk("rev_IN0", 32'(IN[1:0]), 32'h1);
      chk("busy0_after_rev", 32'(busy[0]), 32'h0);

      // Reversal reverted during ramp-down: back to RUN reverse, no dead time.
      send(0, 1'b1, 1'b1, 8);
      run(10);
      send(0, 1'b1, 1'b0, 8);
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         cyc();
         if (IN[1:0] != 2'b01) seen = 1'b1;
      end
      chk("revert_no_dead", 32'(seen), 32'h0);

      // Out-of-range channel: accepted, nothing changes.
      send(1, 1'b1, 1'b1, 6);
      run(70);
      send(5, 1'b1, 1'b0, 15);
      run(40);

      // Reset in the middle of a dead time.
      send(0, 1'b1, 1'b1, 12);
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         cyc();
         if (ph[0] == M_DEAD) seen = 1'b1;
      end
      chk("reach_dead_bound", 32'(seen), 32'h1);
      run(3);
      rst_n = 1'b0;
      cyc();
      chk("middead_rst_IN", 32'(IN), 32'h0);
      chk("middead_rst_EN", 32'(EN), 32'h0);
      chk("middead_rst_busy", 32'(busy), 32'h0);
      rst_n = 1'b1;
      cyc();

      // Randomized commands with occasional resets.
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 2499) == 0) rst_n = 1'b0;
         else rst_n = 1'b1;
         cmd_valid = ($urandom_range(0, 29) == 0);
         cmd_ch    = 3'($urandom_range(0, 7));
         cmd_en    = ($urandom_range(0, 4) != 0);
         cmd_dir   = 1'($urandom);
         cmd_duty  = W'($urandom);
         cyc();
      end
      cmd_valid = 1'b0;
      rst_n = 1'b1;
      run(5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
